// File: rtl/interrupt_ack_decoder.sv
// Interrupt acknowledge decoder: latches the priority-encoder winner, drives a one-hot ack
// to the matching request line and holds it until completion, abort or timeout.
module interrupt_ack_decoder #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] code,
  input  logic       noSig,
  input  logic       serviceDone,
  output logic [3:0] ack,
  output logic [1:0] activeCode,
  output logic       busy,
  output logic       timeoutErr
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACK     = 2'b01,
    RELEASE = 2'b10
  } state_t;

  localparam bit             TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LAST_CNT = TO_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] count_r;

  // Encoder code 00 is the highest-numbered line, so the ack bit is 3-code.
  function automatic logic [3:0] decode_ack(input logic [1:0] c);
    logic [3:0] onehot;
    case (c)
      2'b00:   onehot = 4'b1000;
      2'b01:   onehot = 4'b0100;
      2'b10:   onehot = 4'b0010;
      2'b11:   onehot = 4'b0001;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  // Acknowledge FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= {CNT_W{1'b0}};
      ack        <= 4'b0000;
      activeCode <= 2'b00;
      busy       <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      timeoutErr <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable && !noSig) begin
            activeCode <= code;
            ack        <= decode_ack(code);
            count_r    <= {CNT_W{1'b0}};
            busy       <= 1'b1;
            state_r    <= ACK;
          end else begin
            ack  <= 4'b0000;
            busy <= 1'b0;
          end
        end
        ACK: begin
          // Abort beats completion beats expiry, so a same-edge serviceDone suppresses the error.
          if (!enable) begin
            ack     <= 4'b0000;
            state_r <= RELEASE;
          end else if (serviceDone) begin
            ack     <= 4'b0000;
            state_r <= RELEASE;
          end else if (TO_EN && (count_r == LAST_CNT)) begin
            ack        <= 4'b0000;
            timeoutErr <= 1'b1;
            state_r    <= RELEASE;
          end else begin
            count_r <= count_r + CNT_ONE;
          end
        end
        RELEASE: begin
          ack     <= 4'b0000;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ack     <= 4'b0000;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
